wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 162 ++++++++++++++++
 tb/tb_wb_burst_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// wb_burst_master: turns one request (addr/len/sel/we) into a Wishbone B3 incrementing burst.
// Latency: first beat presented the cycle after acceptance; read data appears one cycle after each ack.
// Backpressure: req_ready only in IDLE; write data stalls stb via wr_valid; read data has no backpressure.
// Ports: clk/rst_n; request side req_valid/req_ready/req_we/req_addr/req_len/req_sel;
//        write stream wr_data/wr_valid/wr_ready; read stream rd_data/rd_valid; status done/err;
//        Wishbone master wbm_cyc_o/stb_o/we_o/addr_o/sel_o/cti_o/bte_o/data_o, wbm_data_i/ack_i/err_i.
// Optional watchdog: define WB_MASTER_TIMEOUT_EN to abort a burst after TIMEOUT cycles without ack.
module wb_burst_master #(
  parameter int LEN_BITS = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:2]         req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  input  logic [3:0]          req_sel,
  input  logic [31:0]         wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  output logic                done,
  output logic                err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [31:2]         wbm_addr_o,
  output logic [3:0]          wbm_sel_o,
  output logic [2:0]          wbm_cti_o,
  output logic [1:0]          wbm_bte_o,
  output logic [31:0]         wbm_data_o,
  input  logic [31:0]         wbm_data_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              state;
  logic [31:2]         addr_q;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] cnt_q;
  logic [3:0]          sel_q;
  logic                we_q;

  logic in_xfer;
  logic stb;
  logic beat;
  logic last_beat;
  logic abort;
  logic timeout_hit;

  assign in_xfer = (state == XFER);
  // Writes only strobe when a data word is available; reads strobe every XFER cycle.
  assign stb     = in_xfer & (we_q ? wr_valid : 1'b1);
  // An error on the same edge as an ack wins: that beat does not count.
  assign beat      = stb & wbm_ack_i & ~wbm_err_i;
  assign last_beat = beat & (cnt_q == len_q);
  assign abort     = in_xfer & (wbm_err_i | timeout_hit);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q;

  // Abort on the edge where the counter would reach TIMEOUT, unless an ack arrives on it.
  assign timeout_hit = in_xfer & ~wbm_ack_i & (tmr_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (!in_xfer || wbm_ack_i) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    wbm_cti_o = 3'b000;
    if (in_xfer && (len_q != '0)) begin
      wbm_cti_o = (cnt_q == len_q) ? 3'b111 : 3'b010;
    end
  end

  assign req_ready  = (state == IDLE);
  assign wbm_cyc_o  = in_xfer;
  assign wbm_stb_o  = stb;
  assign wbm_we_o   = in_xfer & we_q;
  assign wbm_addr_o = addr_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_bte_o  = 2'b00;
  assign wbm_data_o = wr_data;
  assign wr_ready   = in_xfer & we_q & wbm_ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (req_valid) begin
            addr_q <= req_addr;
            len_q  <= req_len;
            sel_q  <= req_sel;
            we_q   <= req_we;
            cnt_q  <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (beat) begin
            addr_q <= addr_q + 30'd1;
            cnt_q  <= cnt_q + LEN_BITS'(1);
            if (!we_q) begin
              rd_valid <= 1'b1;
              rd_data  <= wbm_data_i;
            end
            if (last_beat) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:2]   req_addr = '0;
  logic [LB-1:0] req_len = '0;
  logic [3:0]    req_sel = '0;
  logic [31:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [31:2]   wbm_addr_o;
  logic [3:0]    wbm_sel_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic [31:0]   wbm_data_o;
  logic [31:0]   wbm_data_i = '0;
  logic          wbm_ack_i = 1'b0;
  logic          wbm_err_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_burst_master #(.LEN_BITS(LB), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_sel(req_sel),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_addr_o(wbm_addr_o), .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_data_o(wbm_data_o),
    .wbm_data_i(wbm_data_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete burst. The reference is the transaction itself: beat i sits at
  // start+i (mod 2^30), carries write word i, and reads return the word the slave
  // handed over on the acking cycle, one cycle later.
  task automatic run_burst(input bit we, input logic [29:0] addr, input int len,
                           input logic [3:0] sel, input int err_beat, input int gap_beat,
                           input int ack_pct, input int vld_pct, input logic [31:0] first_word,
                           output int rd_pulses);
    logic [29:0] a_exp;
    logic [31:0] wq[$];
    logic [31:0] pend_dat;
    logic [2:0]  cti_exp;
    int beat, sc, cycles;
    bit aborted, finished, gap_done, pend, v, fire, ak, er;
    a_exp = addr; beat = 0; sc = 0; cycles = 0; rd_pulses = 0;
    aborted = 0; finished = 0; gap_done = 0; pend = 0; pend_dat = '0;
    for (int i = 0; i <= len; i++) wq.push_back((i == 0) ? first_word : $urandom);

    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = LB'(len); req_sel = sel;
    #1 check("req_ready_idle", req_ready, 1'b1);
    tick();
    // Scramble the request inputs so a design that fails to latch them shows up.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 30'($urandom);
    req_len = LB'($urandom); req_sel = 4'($urandom);

    while (!finished) begin
      check("rd_valid", rd_valid, pend);
      if (pend) check("rd_data", rd_data, pend_dat);
      pend = 0;
      check("cyc_busy", wbm_cyc_o, 1'b1);
      check("req_ready_busy", req_ready, 1'b0);
      check("done_busy", done, 1'b0);

      v = 1;
      if (we) begin
        v = (sc >= 3) || ($urandom_range(99) < vld_pct);
        if (beat == gap_beat && !gap_done) begin v = 0; gap_done = 1; end
      end
      fire = v && ((sc >= 3) || ($urandom_range(99) < ack_pct));
      er   = fire && (beat == err_beat);
      ak   = fire && (!er || ($urandom_range(1) == 1));
      wr_valid   = we ? v : 1'($urandom);
      wr_data    = we ? wq[beat] : $urandom;
      wbm_ack_i  = ak;
      wbm_err_i  = er;
      wbm_data_i = $urandom;
      #1;
      cti_exp = (len == 0) ? 3'b000 : ((beat == len) ? 3'b111 : 3'b010);
      check("stb", wbm_stb_o, we ? v : 1'b1);
      check("addr", wbm_addr_o, a_exp);
      check("cti", wbm_cti_o, cti_exp);
      check("we", wbm_we_o, we);
      check("sel", wbm_sel_o, sel);
      check("bte", wbm_bte_o, 2'b00);
      check("wr_ready", wr_ready, we & ak);
      if (we && v) check("wdata", wbm_data_o, wq[beat]);

      if (er) begin
        aborted = 1; finished = 1;
      end else if (ak) begin
        if (!we) begin pend = 1; pend_dat = wbm_data_i; rd_pulses++; end
        beat++; a_exp = a_exp + 30'd1; sc = 0;
        if (beat > len) finished = 1;
      end else begin
        sc++;
      end
      cycles++;
      if (cycles > 300) begin
        vectors++; miscompares++;
        $error("FAIL cycle_budget: burst still running after %0d cycles, expected completion", cycles);
        finished = 1;
      end
      tick();
    end

    // FIN cycle: Wishbone responses must be ignored here.
    check("fin_rd_valid", rd_valid, pend);
    if (pend) check("fin_rd_data", rd_data, pend_dat);
    check("fin_done", done, 1'b1);
    check("fin_err", err, aborted);
    check("fin_cyc", wbm_cyc_o, 1'b0);
    check("fin_req_ready", req_ready, 1'b0);
    wr_valid = 1'b0; wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom);
    #1;
    check("fin_stb", wbm_stb_o, 1'b0);
    check("fin_wr_ready", wr_ready, 1'b0);
    tick();
    check("idle_done", done, 1'b0);
    check("idle_err", err, 1'b0);
    check("idle_rd_valid", rd_valid, 1'b0);
    check("idle_cyc", wbm_cyc_o, 1'b0);
    check("idle_req_ready", req_ready, 1'b1);
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
  endtask

  initial begin
    int rdp;
    int len, eb;
    logic [29:0] a;

    // Reset state.
    #3;
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_stb", wbm_stb_o, 1'b0);
    check("rst_we", wbm_we_o, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_cti", wbm_cti_o, 3'b000);
    check("rst_sel", wbm_sel_o, 4'h0);
    check("rst_addr", wbm_addr_o, 30'h0);
    check("rst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("req_ready_after_reset", req_ready, 1'b1);

    // Read 0x100, len 3, zero-wait acks.
    run_burst(1'b0, 30'h100, 3, 4'hF, -1, -1, 100, 100, 32'h0, rdp);
    check("rd_pulses_len3", rdp, 4);
    // Single-beat write with partial selects.
    run_burst(1'b1, 30'h040, 0, 4'b0011, -1, -1, 100, 100, 32'hDEADBEEF, rdp);
    // Write len 2 with a wr_valid gap before beat 2.
    run_burst(1'b1, 30'h200, 2, 4'hF, -1, 1, 100, 100, 32'h12345678, rdp);
    // Read len 7, error on beat 3.
    run_burst(1'b0, 30'h300, 7, 4'hF, 2, -1, 100, 100, 32'h0, rdp);
    check("rd_pulses_err", rdp, 2);
    // Address wrap.
    run_burst(1'b0, 30'h3FFFFFFF, 1, 4'hC, -1, -1, 100, 100, 32'h0, rdp);
    check("rd_pulses_wrap", rdp, 2);

    // Randomized bursts.
    for (int n = 0; n < 24; n++) begin
      len = $urandom_range(15);
      a = ($urandom_range(3) == 0) ? (30'h3FFFFFF0 + 30'($urandom_range(15))) : 30'($urandom);
      eb = ($urandom_range(4) == 0) ? $urandom_range(len) : -1;
      run_burst(1'($urandom), a, len, 4'($urandom), eb, -1,
                $urandom_range(100, 30), $urandom_range(100, 40), $urandom, rdp);
    end

    // Reset in the middle of a read burst abandons it with no done pulse.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 30'h500; req_len = 4'd7; req_sel = 4'hF;
    tick();
    req_valid = 1'b0; wbm_ack_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", wbm_cyc_o, 1'b0);
    check("mid_rst_stb", wbm_stb_o, 1'b0);
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_addr", wbm_addr_o, 30'h0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    wbm_ack_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", done, 1'b0);
      check("post_rst_cyc", wbm_cyc_o, 1'b0);
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Slave never responds: watchdog ends the burst 15 cycles after XFER entry.
    begin
      int seen;
      seen = -1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 30'h600; req_len = 4'd3; req_sel = 4'hF;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 25; k++) begin
        tick();
        if (done && seen < 0) begin
          seen = k;
          check("timeout_err", err, 1'b1);
        end
      end
      check("timeout_cycle", seen, 15);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not reach its end, expected completion");
    $fatal(1);
  end

endmodule
